// File: rtl/ex2_result_stage_pkg.sv
// Shared JX2 definitions used by the EX2 result stage: register IDs,
// memory response codes and the EX2 slot state encoding.
package ex2_result_stage_pkg;

    localparam logic [5:0] JX2_GR_R0  = 6'h00;
    localparam logic [5:0] JX2_GR_SP  = 6'h0F;
    localparam logic [5:0] JX2_GR_DLR = 6'h10;
    localparam logic [5:0] JX2_GR_DHR = 6'h11;
    localparam logic [5:0] JX2_GR_ZZR = 6'h3F;

    localparam logic [1:0] UMEM_OK_READY = 2'd0;
    localparam logic [1:0] UMEM_OK_OK    = 2'd1;
    localparam logic [1:0] UMEM_OK_HOLD  = 2'd2;
    localparam logic [1:0] UMEM_OK_FAULT = 2'd3;

    typedef enum logic [0:0] {
        EX2_RUN     = 1'b0,
        EX2_MEMWAIT = 1'b1
    } ex2State_t;

    function automatic logic jx2IsRealReg(input logic [5:0] regId);
        return (regId != JX2_GR_ZZR);
    endfunction

endpackage

// File: rtl/ex2_result_stage_hazard_cmp.sv
// Load-use comparator: flags a decode source that needs a value still in flight
// from a load in EX1.
module ex2_hazard_cmp
    import ex2_result_stage_pkg::*;
(
    input  logic       isLoad,
    input  logic [5:0] idRn,
    input  logic [5:0] idRs,
    input  logic [5:0] idRt,
    input  logic [5:0] idRm,
    output logic       stall
);

    logic srcMatch;

    assign srcMatch = (idRn == idRs) | (idRn == idRt) | (idRn == idRm);
    assign stall    = isLoad & jx2IsRealReg(idRn) & srcMatch;

endmodule

// File: rtl/ex2_result_stage.sv
// EX2 result slot: registers the EX1 result, waits for load data from memory,
// and drives the two GPR forwarding/write ports plus pipeline hold and interlock.
module ex2_result_stage
    import ex2_result_stage_pkg::*;
#(
    parameter logic [7:0] MEM_TIMEOUT = 8'd255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        holdIn,
    input  logic [5:0]  exIdRn,
    input  logic [63:0] exValRn,
    input  logic        exIsLoad,
    input  logic [5:0]  idRegRs,
    input  logic [5:0]  idRegRt,
    input  logic [5:0]  idRegRm,
    input  logic [1:0]  memOK,
    input  logic [63:0] memData,
    output logic [5:0]  regIdRn1,
    output logic [63:0] regValRn1,
    output logic [5:0]  regIdRn2,
    output logic [63:0] regValRn2,
    output logic        holdOut,
    output logic        idStall,
    output logic        exFault
);

    ex2State_t   state;
    ex2State_t   stateNxt;
    logic [5:0]  ex2Id;
    logic [5:0]  ex2IdNxt;
    logic [63:0] ex2Val;
    logic [63:0] ex2ValNxt;
    logic [7:0]  tmoCnt;
    logic [7:0]  tmoCntNxt;
    logic        exFaultNxt;

    logic        memDone;
    logic        memFault;
    logic [63:0] memVal;

    // Load values only exist in EX2, so EX1 never forwards a load destination.
    assign regIdRn1  = exIsLoad ? JX2_GR_ZZR : exIdRn;
    assign regValRn1 = exValRn;

    ex2_hazard_cmp uHazard (
        .isLoad (exIsLoad),
        .idRn   (exIdRn),
        .idRs   (idRegRs),
        .idRt   (idRegRt),
        .idRm   (idRegRm),
        .stall  (idStall)
    );

    // Memory completion decode; OK outranks FAULT, which outranks timeout.
    always_comb begin
        memDone  = 1'b0;
        memFault = 1'b0;
        memVal   = 64'h0;
        if (state == EX2_MEMWAIT) begin
            if (memOK == UMEM_OK_OK) begin
                memDone = 1'b1;
                memVal  = memData;
            end else if (memOK == UMEM_OK_FAULT) begin
                memDone  = 1'b1;
                memFault = 1'b1;
            end else if (tmoCnt == MEM_TIMEOUT) begin
                memDone  = 1'b1;
                memFault = 1'b1;
            end else begin
                memDone  = 1'b0;
                memFault = 1'b0;
            end
        end else begin
            memDone  = 1'b0;
            memFault = 1'b0;
        end
    end

    // EX2 write port; hidden while a load is still outstanding.
    always_comb begin
        regIdRn2  = ex2Id;
        regValRn2 = ex2Val;
        holdOut   = holdIn;
        case (state)
            EX2_RUN: begin
                regIdRn2  = ex2Id;
                regValRn2 = ex2Val;
            end
            EX2_MEMWAIT: begin
                if (memDone) begin
                    regIdRn2  = ex2Id;
                    regValRn2 = memVal;
                end else begin
                    regIdRn2  = JX2_GR_ZZR;
                    regValRn2 = 64'h0;
                    holdOut   = 1'b1;
                end
            end
            default: begin
                regIdRn2  = JX2_GR_ZZR;
                regValRn2 = 64'h0;
            end
        endcase
    end

    // Slot next-state: accept EX1 whenever the pipe moves, else retain.
    always_comb begin
        stateNxt   = state;
        ex2IdNxt   = ex2Id;
        ex2ValNxt  = ex2Val;
        tmoCntNxt  = tmoCnt;
        exFaultNxt = memDone & memFault;
        case (state)
            EX2_RUN: begin
                stateNxt = EX2_RUN;
            end
            EX2_MEMWAIT: begin
                if (memDone) begin
                    stateNxt  = EX2_RUN;
                    ex2ValNxt = memVal;
                end else begin
                    tmoCntNxt = tmoCnt + 8'd1;
                end
            end
            default: begin
                stateNxt = EX2_RUN;
            end
        endcase
        if (!holdOut) begin
            ex2IdNxt  = exIdRn;
            ex2ValNxt = exValRn;
            if (exIsLoad && jx2IsRealReg(exIdRn)) begin
                stateNxt  = EX2_MEMWAIT;
                tmoCntNxt = 8'd0;
            end else begin
                stateNxt = EX2_RUN;
            end
        end else begin
            ex2IdNxt = ex2IdNxt;
        end
    end

    // Slot registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state   <= EX2_RUN;
            ex2Id   <= JX2_GR_ZZR;
            ex2Val  <= 64'h0;
            tmoCnt  <= 8'd0;
            exFault <= 1'b0;
        end else begin
            state   <= stateNxt;
            ex2Id   <= ex2IdNxt;
            ex2Val  <= ex2ValNxt;
            tmoCnt  <= tmoCntNxt;
            exFault <= exFaultNxt;
        end
    end

endmodule

// File: tb/tb_ex2_result_stage.sv
// Self-checking bench for ex2_result_stage: scoreboard of expected GPR writes on
// the Rn2 port plus directed checks of forwarding, hold, interlock and faults.
module tb_ex2_result_stage;
    import ex2_result_stage_pkg::*;

    localparam logic [7:0] TMO = 8'd4;

    logic        clock;
    logic        reset;
    logic        holdIn;
    logic [5:0]  exIdRn;
    logic [63:0] exValRn;
    logic        exIsLoad;
    logic [5:0]  idRegRs;
    logic [5:0]  idRegRt;
    logic [5:0]  idRegRm;
    logic [1:0]  memOK;
    logic [63:0] memData;
    logic [5:0]  regIdRn1;
    logic [63:0] regValRn1;
    logic [5:0]  regIdRn2;
    logic [63:0] regValRn2;
    logic        holdOut;
    logic        idStall;
    logic        exFault;

    int testsRun    = 0;
    int testsFailed = 0;
    logic [69:0] sbQueue[$];

    ex2_result_stage #(.MEM_TIMEOUT(TMO)) dut (
        .clock     (clock),
        .reset     (reset),
        .holdIn    (holdIn),
        .exIdRn    (exIdRn),
        .exValRn   (exValRn),
        .exIsLoad  (exIsLoad),
        .idRegRs   (idRegRs),
        .idRegRt   (idRegRt),
        .idRegRm   (idRegRm),
        .memOK     (memOK),
        .memData   (memData),
        .regIdRn1  (regIdRn1),
        .regValRn1 (regValRn1),
        .regIdRn2  (regIdRn2),
        .regValRn2 (regValRn2),
        .holdOut   (holdOut),
        .idStall   (idStall),
        .exFault   (exFault)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkVal(input string tag, input logic [69:0] obs, input logic [69:0] exp);
        testsRun++;
        if (obs !== exp) begin
            testsFailed++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // GPR write monitor: a write happens at an edge with the pipe moving and Rn2 real.
    always @(negedge clock) begin
        if (reset === 1'b1 && holdOut === 1'b0 && regIdRn2 !== JX2_GR_ZZR) begin
            if (sbQueue.size() == 0) begin
                checkVal("sbUnexpected", {regIdRn2, regValRn2}, {JX2_GR_ZZR, 64'h0});
            end else begin
                checkVal("sbWrite", {regIdRn2, regValRn2}, sbQueue.pop_front());
            end
        end
    end

    task automatic nextCycle();
        @(posedge clock);
        #1;
    endtask

    task automatic bubble();
        exIdRn   = JX2_GR_ZZR;
        exValRn  = 64'h0;
        exIsLoad = 1'b0;
    endtask

    task automatic issueAlu(input logic [5:0] id, input logic [63:0] val);
        exIdRn = id; exValRn = val; exIsLoad = 1'b0;
        sbQueue.push_back({id, val});
        #1;
        checkVal("aluRn1", {regIdRn1, regValRn1}, {id, val});
        checkVal("aluHold0", holdOut, 1'b0);
        nextCycle();
        bubble();
        #1;
        checkVal("aluRn2", {regIdRn2, regValRn2}, {id, val});
        checkVal("aluHold1", holdOut, 1'b0);
        nextCycle();
    endtask

    // Load with nHold HOLD cycles, then finalCode (HOLD here means timeout).
    task automatic issueLoad(input logic [5:0] id, input int nHold,
                             input logic [1:0] finalCode, input logic [63:0] data);
        logic [63:0] expVal;
        exIdRn = id; exValRn = 64'hBAD0BAD0; exIsLoad = 1'b1;
        #1;
        checkVal("ldRn1Zzr", regIdRn1, JX2_GR_ZZR);
        nextCycle();
        bubble();
        for (int i = 0; i < nHold; i++) begin
            memOK = UMEM_OK_HOLD;
            #1;
            checkVal("ldWaitHold", holdOut, 1'b1);
            checkVal("ldWaitRn2", regIdRn2, JX2_GR_ZZR);
            checkVal("ldWaitFault", exFault, 1'b0);
            nextCycle();
        end
        expVal = (finalCode == UMEM_OK_OK) ? data : 64'h0;
        memOK = finalCode; memData = data;
        sbQueue.push_back({id, expVal});
        #1;
        checkVal("ldDoneRn2", {regIdRn2, regValRn2}, {id, expVal});
        checkVal("ldDoneHold", holdOut, 1'b0);
        nextCycle();
        memOK = UMEM_OK_READY; memData = 64'h0;
        #1;
        checkVal("ldFaultPulse", exFault, (finalCode != UMEM_OK_OK));
        checkVal("ldAfterHold", holdOut, 1'b0);
        nextCycle();
        checkVal("ldFaultEnd", exFault, 1'b0);
    endtask

    initial begin
        reset = 1'b0; holdIn = 1'b0; bubble();
        idRegRs = 6'd1; idRegRt = 6'd2; idRegRm = 6'd3;
        memOK = UMEM_OK_READY; memData = 64'h0;
        nextCycle(); nextCycle();
        checkVal("rstRn2", {regIdRn2, regValRn2}, {JX2_GR_ZZR, 64'h0});
        checkVal("rstFault", exFault, 1'b0);
        holdIn = 1'b1; #1;
        checkVal("rstHoldIn", holdOut, 1'b1);
        holdIn = 1'b0; #1;
        checkVal("rstHold0", holdOut, 1'b0);
        reset = 1'b1;
        nextCycle();

        issueAlu(6'd5, 64'h1234);
        issueAlu(6'd12, 64'hFFFF_0000_A5A5_0001);

        issueLoad(6'd7, 0, UMEM_OK_OK, 64'hDEAD);
        issueLoad(6'd7, 3, UMEM_OK_OK, 64'hCAFE_F00D);
        issueLoad(6'd20, 1, UMEM_OK_FAULT, 64'h5555);
        issueLoad(6'd21, TMO, UMEM_OK_HOLD, 64'h7777);

        // Load-use interlock (held so nothing enters the slot).
        holdIn = 1'b1;
        exIsLoad = 1'b1; exIdRn = 6'd9; idRegRt = 6'd9;
        #1;
        checkVal("luStall", idStall, 1'b1);
        checkVal("luRn1", regIdRn1, JX2_GR_ZZR);
        idRegRt = 6'd2; idRegRm = 6'd9; #1;
        checkVal("luStallRm", idStall, 1'b1);
        exIsLoad = 1'b0; #1;
        checkVal("luNoLoad", idStall, 1'b0);
        exIsLoad = 1'b1; exIdRn = JX2_GR_ZZR; idRegRs = JX2_GR_ZZR; #1;
        checkVal("luZzr", idStall, 1'b0);
        idRegRs = 6'd1; idRegRm = 6'd3;
        holdIn = 1'b0;
        // Load to ZZR must not enter MEMWAIT.
        nextCycle();
        bubble(); #1;
        checkVal("ldZzrNoWait", holdOut, 1'b0);
        nextCycle();

        // holdIn during OK completion: value captured, no re-wait.
        exIdRn = 6'd7; exIsLoad = 1'b1; exValRn = 64'h1;
        nextCycle();
        bubble();
        holdIn = 1'b1; memOK = UMEM_OK_OK; memData = 64'hBEEF;
        sbQueue.push_back({6'd7, 64'hBEEF});
        #1;
        checkVal("hiDoneRn2", {regIdRn2, regValRn2}, {6'd7, 64'hBEEF});
        nextCycle();
        memOK = UMEM_OK_HOLD; memData = 64'h0; #1;
        checkVal("hiCaptured", {regIdRn2, regValRn2}, {6'd7, 64'hBEEF});
        checkVal("hiFault", exFault, 1'b0);
        holdIn = 1'b0; #1;
        checkVal("hiNoRewait", holdOut, 1'b0);
        nextCycle();
        memOK = UMEM_OK_READY;
        nextCycle();

        // Completion with holdIn=0 accepts the next EX1 op at the same edge.
        exIdRn = 6'd3; exIsLoad = 1'b1;
        nextCycle();
        exIdRn = 6'd4; exValRn = 64'h44; exIsLoad = 1'b0;
        memOK = UMEM_OK_OK; memData = 64'h3333;
        sbQueue.push_back({6'd3, 64'h3333});
        sbQueue.push_back({6'd4, 64'h44});
        nextCycle();
        bubble(); memOK = UMEM_OK_READY; #1;
        checkVal("b2bRn2", {regIdRn2, regValRn2}, {6'd4, 64'h44});
        nextCycle();

        // Reset in MEMWAIT aborts the load with no write and no fault.
        exIdRn = 6'd8; exIsLoad = 1'b1;
        nextCycle();
        bubble(); memOK = UMEM_OK_HOLD;
        nextCycle();
        reset = 1'b0; memOK = UMEM_OK_FAULT;
        nextCycle();
        memOK = UMEM_OK_READY; #1;
        checkVal("rstAbortRn2", {regIdRn2, regValRn2}, {JX2_GR_ZZR, 64'h0});
        checkVal("rstAbortFault", exFault, 1'b0);
        checkVal("rstAbortHold", holdOut, 1'b0);
        reset = 1'b1;
        nextCycle();
        checkVal("rstAbortFault2", exFault, 1'b0);
        checkVal("rstAbortRn2b", regIdRn2, JX2_GR_ZZR);

        nextCycle(); nextCycle();
        checkVal("sbEmpty", sbQueue.size(), 0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
